cam_capture: RTL and testbench

Parametrised camera pixel-capture engine, successor to the fixed 8-to-16-bit OV5640 capture path. Samples the sensor DVP bus (href/vsync/data) in the pixel-clock domain and packs one or two bus bytes into an output word. Adds the following over the fixed path:
- power-up frame skipping;
- per-frame crop window;
- frame decimation;
- byte-order selection;
- frame start, end-of-line and frame-done markers;
- sticky error flags.

Its output drives the SDRAM write FIFO (m_data/m_wr_en).

---
 rtl/cam_capture_if.sv | 37 +++
 rtl/cam_capture.sv | 171 +++++++++++++++++
 tb/tb_cam_capture.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_if.sv
// cam_capture_if: sensor DVP bus, capture configuration and packed-pixel write port of cam_capture.
// master drives enable, cam_href/cam_vsync/cam_data, win_*, dec_n, swap, clr_err;
// slave (the capture engine) drives m_data/m_wr_en/m_sof/m_eol, frame_done, frame_cnt, busy, err_odd, err_len.
interface cam_capture_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int CW    = 12
);
    logic            enable;
    logic            cam_href;
    logic            cam_vsync;
    logic [IN_W-1:0] cam_data;
    logic [CW-1:0]   win_x0;
    logic [CW-1:0]   win_y0;
    logic [CW-1:0]   win_w;
    logic [CW-1:0]   win_h;
    logic [3:0]      dec_n;
    logic            swap;
    logic            clr_err;
    logic [OUT_W-1:0] m_data;
    logic            m_wr_en;
    logic            m_sof;
    logic            m_eol;
    logic            frame_done;
    logic [15:0]     frame_cnt;
    logic            busy;
    logic            err_odd;
    logic            err_len;
    modport master (
        output enable, cam_href, cam_vsync, cam_data, win_x0, win_y0, win_w, win_h, dec_n, swap, clr_err,
        input  m_data, m_wr_en, m_sof, m_eol, frame_done, frame_cnt, busy, err_odd, err_len
    );
    modport slave (
        input  enable, cam_href, cam_vsync, cam_data, win_x0, win_y0, win_w, win_h, dec_n, swap, clr_err,
        output m_data, m_wr_en, m_sof, m_eol, frame_done, frame_cnt, busy, err_odd, err_len
    );
endinterface

// File: rtl/cam_capture.sv
// cam_capture: DVP camera capture with frame skip, crop window, decimation, byte packing and error flags.
// sclk: sensor pixel clock; s_rst_n: synchronous active-low reset;
// bus: slave side of cam_capture_if (sensor bus and configuration in, packed pixel stream and status out).
module cam_capture #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 16,
    parameter int SKIP_FRAMES = 10,
    parameter int CW          = 12
) (
    input logic           sclk,
    input logic           s_rst_n,
    cam_capture_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SKIP, WAIT, ACT, DONE} st_t;
    st_t st_q, st_d;
    logic [7:0] skip_q, skip_d;
    logic href_q, href_p_q, vs_q, vs_p_q;
    logic [IN_W-1:0] dat_q;
    logic fb, vf, hf, hv, act, go;
    logic [3:0] ph_q;
    logic keep_q, sofp_q;
    logic [CW-1:0] x_q, y_q, len_q, x0_q, y0_q, w_q, h_q;
    logic pv, odd;
    logic [OUT_W-1:0] pd;
    logic [CW:0] xend, yend;
    logic inx, iny, wr, sofc, eolc, lk, len_set;
    logic p_v_q, p_sof_q, o_v_q, o_sof_q, o_eol_q;
    logic [OUT_W-1:0] p_d_q, o_d_q;
    logic err_odd_q, err_len_q;
    logic [15:0] fcnt_q;
    assign fb  = vs_q & ~vs_p_q;
    assign vf  = ~vs_q & vs_p_q;
    assign hf  = ~href_q & href_p_q;
    assign hv  = href_q & ~fb;
    assign act = st_q == ACT;
    assign go  = st_q == WAIT && st_d == ACT;
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            st_q   <= IDLE;
            skip_q <= '0;
        end else begin
            st_q   <= st_d;
            skip_q <= skip_d;
        end
    end
    always_comb begin
        st_d   = st_q;
        skip_d = skip_q;
        case (st_q)
            IDLE: if (bus.enable) begin
                st_d   = SKIP;
                skip_d = 8'(SKIP_FRAMES);
                if (SKIP_FRAMES == 0) st_d = WAIT;
            end
            SKIP: if (!bus.enable) st_d = IDLE;
                  else if (fb) begin
                      skip_d = skip_q - 8'd1;
                      if (skip_q <= 8'd1) st_d = WAIT;
                  end
            WAIT: if (!bus.enable) st_d = IDLE;
                  else if (vf) st_d = ACT;
            ACT:  if (fb) st_d = DONE;
            DONE: st_d = bus.enable ? WAIT : IDLE;
            default: st_d = IDLE;
        endcase
    end
    if (OUT_W == 2 * IN_W) begin : g_two
        logic bp_q;
        logic [IN_W-1:0] hold_q;
        always_ff @(posedge sclk) begin
            if (!s_rst_n) begin
                bp_q   <= 1'b0;
                hold_q <= '0;
            end else begin
                bp_q <= hv & ~bp_q;
                if (hv & ~bp_q) hold_q <= dat_q;
            end
        end
        assign pv  = hv & bp_q;
        // href dropped while the first byte of a pixel is still held
        assign odd = ~href_q & bp_q;
        assign pd  = bus.swap ? {dat_q, hold_q} : {hold_q, dat_q};
    end else begin : g_one
        assign pv  = hv;
        assign odd = 1'b0;
        assign pd  = OUT_W'(dat_q);
    end
    // window bounds at CW+1 bits so origin+size cannot wrap
    assign xend    = {1'b0, x0_q} + {1'b0, w_q};
    assign yend    = {1'b0, y0_q} + {1'b0, h_q};
    assign inx     = x_q >= x0_q && (w_q == '0 || {1'b0, x_q} < xend);
    assign iny     = y_q >= y0_q && (h_q == '0 || {1'b0, y_q} < yend);
    assign wr      = pv & act & keep_q & inx & iny;
    assign sofc    = wr & sofp_q;
    assign eolc    = w_q != '0 && {1'b0, x_q} == xend - (CW+1)'(1);
    // full-width lines: end of line is only known one pixel later
    assign lk      = w_q == '0;
    assign len_set = act & hf & (y_q != '0) & (x_q != len_q);
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            href_q    <= 1'b0;
            href_p_q  <= 1'b0;
            // start as if in blanking so leaving reset never fakes a frame edge
            vs_q      <= 1'b1;
            vs_p_q    <= 1'b1;
            dat_q     <= '0;
            ph_q      <= '0;
            keep_q    <= 1'b0;
            sofp_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            len_q     <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            p_v_q     <= 1'b0;
            p_sof_q   <= 1'b0;
            p_d_q     <= '0;
            o_v_q     <= 1'b0;
            o_sof_q   <= 1'b0;
            o_eol_q   <= 1'b0;
            o_d_q     <= '0;
            err_odd_q <= 1'b0;
            err_len_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            href_q   <= bus.cam_href;
            href_p_q <= href_q;
            vs_q     <= bus.cam_vsync;
            vs_p_q   <= vs_q;
            dat_q    <= bus.cam_data;
            if (st_q == IDLE) ph_q <= '0;
            if (go) begin
                x0_q   <= bus.win_x0;
                y0_q   <= bus.win_y0;
                w_q    <= bus.win_w;
                h_q    <= bus.win_h;
                x_q    <= '0;
                y_q    <= '0;
                keep_q <= ph_q == 4'd0;
                ph_q   <= ph_q >= bus.dec_n ? 4'd0 : ph_q + 4'd1;
                sofp_q <= 1'b1;
            end else if (act) begin
                x_q <= hf ? '0 : (pv && !(&x_q)) ? x_q + 1'b1 : x_q;
                if (hf && !(&y_q)) y_q <= y_q + 1'b1;
                if (hf && y_q == '0) len_q <= x_q;
                if (wr) sofp_q <= 1'b0;
            end
            p_v_q     <= wr & lk;
            p_sof_q   <= sofc;
            p_d_q     <= pd;
            o_v_q     <= lk ? p_v_q : wr;
            o_sof_q   <= lk ? p_sof_q : sofc;
            o_eol_q   <= lk ? p_v_q & ~href_q : wr & eolc;
            o_d_q     <= lk ? p_d_q : pd;
            err_odd_q <= (odd & act) | (err_odd_q & ~bus.clr_err);
            err_len_q <= len_set | (err_len_q & ~bus.clr_err);
            if (st_q == DONE && keep_q) fcnt_q <= fcnt_q + 16'd1;
        end
    end
    assign bus.m_data     = o_d_q;
    assign bus.m_wr_en    = o_v_q;
    assign bus.m_sof      = o_sof_q;
    assign bus.m_eol      = o_eol_q;
    assign bus.frame_done = st_q == DONE && keep_q;
    assign bus.frame_cnt  = fcnt_q;
    assign bus.busy       = st_q == SKIP || st_q == WAIT || act;
    assign bus.err_odd    = err_odd_q;
    assign bus.err_len    = err_len_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed self-checking bench for cam_capture (2-byte mode, SKIP_FRAMES=2, 20x6 frames).
module tb_cam_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cam_capture_if #(.IN_W(8), .OUT_W(16), .CW(12)) bus();
    cam_capture #(.IN_W(8), .OUT_W(16), .SKIP_FRAMES(2), .CW(12)) dut (
        .sclk(clk),
        .s_rst_n(rst_n),
        .bus(bus)
    );
    int n_chk = 0, n_err = 0, cyc = 0;
    int n_wr = 0, n_sof = 0, n_eol = 0, n_done = 0;
    int t_sof = 0, t_drv = 0, t_done = 0, t_vs = 0, py = 0, px = 0;
    int d_wr, d_sof, d_eol, d_done;
    int sof_d = 0, eol_d = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.m_wr_en) begin
            n_wr++;
            if (bus.m_sof) begin
                n_sof++;
                sof_d = int'(bus.m_data);
                t_sof = cyc;
            end
            if (bus.m_eol) begin
                n_eol++;
                eol_d = int'(bus.m_data);
            end
        end
        if (bus.frame_done) begin
            n_done++;
            t_done = cyc;
        end
    end
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    // each pixel is byte 0x80|line then byte x
    task automatic line(input int y, input int np, input bit odd);
        for (int x = 0; x < np; x++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = 8'h80 | 8'(y);
            @(negedge clk);
            bus.cam_data = 8'(x);
            if (y == py && x == px) t_drv = cyc;
        end
        if (odd) begin
            @(negedge clk);
            bus.cam_data = 8'hEE;
        end
        @(negedge clk);
        bus.cam_href = 1'b0;
        bus.cam_data = '0;
        repeat (3) @(negedge clk);
    endtask
    task automatic frame(input int sl, input int ol);
        int b_wr, b_sof, b_eol, b_done;
        b_wr = n_wr; b_sof = n_sof; b_eol = n_eol; b_done = n_done;
        @(negedge clk);
        bus.cam_vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < 6; l++) line(l, l == sl ? 18 : 20, l == ol);
        bus.cam_vsync = 1'b1;
        t_vs = cyc;
        repeat (10) @(negedge clk);
        d_wr = n_wr - b_wr; d_sof = n_sof - b_sof; d_eol = n_eol - b_eol; d_done = n_done - b_done;
    endtask
    task automatic clr_pulse();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        int pat, tot;
        bus.enable = 0; bus.cam_href = 0; bus.cam_vsync = 1; bus.cam_data = 0;
        bus.win_x0 = 0; bus.win_y0 = 0; bus.win_w = 0; bus.win_h = 0;
        bus.dec_n = 0; bus.swap = 0; bus.clr_err = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr", bus.m_wr_en, 0);
        check("rst_data", int'(bus.m_data), 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cnt", int'(bus.frame_cnt), 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_err", {bus.err_odd, bus.err_len}, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_on", bus.busy, 1);
        frame(-1, -1);
        check("skip1_wr", d_wr, 0);
        check("skip1_done", d_done, 0);
        frame(-1, -1);
        check("skip2_wr", d_wr, 0);
        frame(-1, -1);
        check("f3_wr", d_wr, 120);
        check("f3_sof", d_sof, 1);
        check("f3_eol", d_eol, 6);
        check("f3_done", d_done, 1);
        check("f3_cnt", int'(bus.frame_cnt), 1);
        check("f3_sofd", sof_d, 'h8000);
        check("f3_eold", eol_d, 'h8513);
        check("f3_lat", t_sof - t_drv, 3);
        check("f3_donelat", t_done - t_vs, 2);
        bus.swap = 1'b1;
        frame(-1, -1);
        bus.swap = 1'b0;
        check("swap_sofd", sof_d, 'h0080);
        check("swap_eold", eol_d, 'h1385);
        check("swap_cnt", int'(bus.frame_cnt), 2);
        bus.win_x0 = 10; bus.win_y0 = 4; bus.win_w = 8; bus.win_h = 2;
        py = 4; px = 10;
        frame(-1, -1);
        bus.win_x0 = 0; bus.win_y0 = 0; bus.win_w = 0; bus.win_h = 0;
        py = 0; px = 0;
        check("crop_wr", d_wr, 16);
        check("crop_sof", d_sof, 1);
        check("crop_eol", d_eol, 2);
        check("crop_sofd", sof_d, 'h840A);
        check("crop_eold", eol_d, 'h8511);
        check("crop_lat", t_sof - t_drv, 2);
        check("crop_cnt", int'(bus.frame_cnt), 3);
        bus.dec_n = 4'd2;
        pat = 0; tot = 0;
        for (int f = 0; f < 6; f++) begin
            frame(-1, -1);
            pat |= d_done << f;
            tot += d_wr;
        end
        bus.dec_n = 4'd0;
        check("dec_pat", pat, 'b001001);
        check("dec_wr", tot, 240);
        check("dec_cnt", int'(bus.frame_cnt), 5);
        frame(-1, 1);
        check("odd_wr", d_wr, 120);
        check("odd_flag", bus.err_odd, 1);
        check("odd_len", bus.err_len, 0);
        check("odd_cnt", int'(bus.frame_cnt), 6);
        clr_pulse();
        check("odd_clr", bus.err_odd, 0);
        frame(3, -1);
        check("len_wr", d_wr, 118);
        check("len_flag", bus.err_len, 1);
        check("len_odd", bus.err_odd, 0);
        clr_pulse();
        check("len_clr", bus.err_len, 0);
        @(negedge clk);
        bus.cam_vsync = 1'b0;
        repeat (3) @(negedge clk);
        line(0, 20, 0);
        line(1, 20, 0);
        pat = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_wr", bus.m_wr_en, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_cnt", int'(bus.frame_cnt), 0);
        check("mrst_data", int'(bus.m_data), 0);
        for (int l = 2; l < 6; l++) line(l, 20, 0);
        bus.cam_vsync = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mrst_nodone", n_done - pat, 0);
        frame(-1, -1);
        tot = d_wr;
        frame(-1, -1);
        check("mrst_skip_wr", tot + d_wr, 0);
        frame(-1, -1);
        check("mrst_wr_after", d_wr, 120);
        check("mrst_done_after", d_done, 1);
        check("mrst_cnt_after", int'(bus.frame_cnt), 1);
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("en_drop", bus.busy, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
